// File: rtl/five_cycle_cpu_pkg.sv
// Shared types, opcode constants and decode/ALU helpers for the five-cycle RV32I core.
package five_cycle_cpu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK} state_t;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_t;

  // Request half of the unified memory port
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mem_req_t;

  // Sign-extended immediate selected by instruction format
  function automatic logic [XLEN-1:0] imm_gen(input logic [XLEN-1:0] ir);
    case (ir[6:0])
      OP_LOAD, OP_IMM, OP_JALR: imm_gen = {{20{ir[31]}}, ir[31:20]};
      OP_STORE:                 imm_gen = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BRANCH:                imm_gen = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm_gen = {ir[31:12], 12'h000};
      OP_JAL:                   imm_gen = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:                  imm_gen = '0;
    endcase
  endfunction

  // funct3 plus the alternate bit (SUB/SRA) to an ALU operation
  function automatic alu_op_t alu_decode(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  alu_decode = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_decode = ALU_SLL;
      3'b010:  alu_decode = ALU_SLT;
      3'b011:  alu_decode = ALU_SLTU;
      3'b100:  alu_decode = ALU_XOR;
      3'b101:  alu_decode = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_decode = ALU_OR;
      default: alu_decode = ALU_AND;
    endcase
  endfunction

  // 32-bit wrapping ALU; shifts use the low five bits of y
  function automatic logic [XLEN-1:0] alu_fn(input alu_op_t op, input logic [XLEN-1:0] x,
                                             input logic [XLEN-1:0] y);
    case (op)
      ALU_ADD:  alu_fn = x + y;
      ALU_SUB:  alu_fn = x - y;
      ALU_AND:  alu_fn = x & y;
      ALU_OR:   alu_fn = x | y;
      ALU_XOR:  alu_fn = x ^ y;
      ALU_SLT:  alu_fn = {31'b0, ($signed(x) < $signed(y))};
      ALU_SLTU: alu_fn = {31'b0, (x < y)};
      ALU_SLL:  alu_fn = x << y[4:0];
      ALU_SRL:  alu_fn = x >> y[4:0];
      ALU_SRA:  alu_fn = XLEN'($signed(x) >>> y[4:0]);
      default:  alu_fn = '0;
    endcase
  endfunction

  // Branch condition by funct3; undefined encodings never branch
  function automatic logic branch_taken(input logic [2:0] funct3, input logic [XLEN-1:0] x,
                                        input logic [XLEN-1:0] y);
    case (funct3)
      3'b000:  branch_taken = (x == y);
      3'b001:  branch_taken = (x != y);
      3'b100:  branch_taken = ($signed(x) < $signed(y));
      3'b101:  branch_taken = ($signed(x) >= $signed(y));
      3'b110:  branch_taken = (x < y);
      3'b111:  branch_taken = (x >= y);
      default: branch_taken = 1'b0;
    endcase
  endfunction

  // Opcodes that produce a register result
  function automatic logic writes_rd(input logic [6:0] opcode);
    writes_rd = (opcode == OP_OP) || (opcode == OP_IMM) || (opcode == OP_LOAD) ||
                (opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL) ||
                (opcode == OP_JALR);
  endfunction

endpackage

// File: rtl/five_cycle_cpu_if.sv
// Unified memory port between the core and its word memory.
interface five_cycle_cpu_if;
  five_cycle_cpu_pkg::mem_req_t req;
  logic [31:0]                  rdata;

  modport master (output req, input rdata);
  modport slave  (input req, output rdata);
endinterface

// File: rtl/cpu_memory.sv
// Unified word memory: combinational read, synchronous full-word write, no reset.
module cpu_memory #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input logic             clk,
  five_cycle_cpu_if.slave bus
);
  localparam int unsigned AW = $clog2(MEM_WORDS);

  logic [31:0]   data [0:MEM_WORDS-1];
  logic [AW-1:0] idx;
  logic          unused_addr_bits;

  // Byte offset ignored, upper address bits wrap
  assign idx              = bus.req.addr[AW+1:2];
  assign unused_addr_bits = ^{bus.req.addr[31:AW+2], bus.req.addr[1:0]};
  assign bus.rdata        = data[idx];

  // Store port
  always_ff @(posedge clk) begin
    if (bus.req.we) data[idx] <= bus.req.wdata;
  end
endmodule

// File: rtl/five_cycle_cpu.sv
// Multi-cycle RV32I-subset core: every instruction takes FETCH..WRITEBACK, five clocks.
module five_cycle_cpu
  import five_cycle_cpu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input logic clk,
  input logic rst
);
  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic [31:0] ir_q, ir_d, a_q, a_d, b_q, b_d, imm_q, imm_d, alu_q, alu_d, mdr_q, mdr_d;
  logic        taken_q, taken_d;
  logic [31:0] regs [0:31];
  logic        rf_we_c;
  logic [31:0] rf_wdata_c;
  mem_req_t    mem_req_c;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        alt;
  logic        is_jump;

  assign opcode  = ir_q[6:0];
  assign rd      = ir_q[11:7];
  assign funct3  = ir_q[14:12];
  assign rs1     = ir_q[19:15];
  assign rs2     = ir_q[24:20];
  assign alt     = ir_q[30];
  assign is_jump = (opcode == OP_JAL) || (opcode == OP_JALR);

  five_cycle_cpu_if mem_bus ();
  assign mem_bus.req = mem_req_c;

  cpu_memory #(.MEM_WORDS(MEM_WORDS)) memory (
    .clk (clk),
    .bus (mem_bus.slave)
  );

  // Memory port: PC outside MEMORY, effective address in MEMORY; stores dropped under reset
  always_comb begin
    mem_req_c.we    = 1'b0;
    mem_req_c.addr  = pc;
    mem_req_c.wdata = b_q;
    if (state == MEMORY) begin
      mem_req_c.addr = alu_q;
      mem_req_c.we   = (opcode == OP_STORE) && !rst;
    end
  end

  // Next-state and datapath updates for the current phase
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    imm_d      = imm_q;
    alu_d      = alu_q;
    taken_d    = taken_q;
    mdr_d      = mdr_q;
    rf_we_c    = 1'b0;
    rf_wdata_c = '0;
    case (state)
      FETCH: begin
        ir_d    = mem_bus.rdata;
        state_d = DECODE;
      end
      DECODE: begin
        a_d     = regs[rs1];
        b_d     = regs[rs2];
        imm_d   = imm_gen(ir_q);
        state_d = EXECUTE;
      end
      EXECUTE: begin
        taken_d = 1'b0;
        case (opcode)
          OP_OP:             alu_d = alu_fn(alu_decode(funct3, alt), a_q, b_q);
          OP_IMM:            alu_d = alu_fn(alu_decode(funct3, (funct3 == 3'b101) && alt), a_q, imm_q);
          OP_LOAD, OP_STORE: alu_d = a_q + imm_q;
          OP_LUI:            alu_d = imm_q;
          OP_AUIPC, OP_JAL:  alu_d = pc + imm_q;
          OP_JALR:           alu_d = (a_q + imm_q) & ~32'h1;
          OP_BRANCH: begin
            alu_d   = pc + imm_q;
            taken_d = branch_taken(funct3, a_q, b_q);
          end
          default:           alu_d = '0;
        endcase
        state_d = MEMORY;
      end
      MEMORY: begin
        if (opcode == OP_LOAD) mdr_d = mem_bus.rdata;
        state_d = WRITEBACK;
      end
      WRITEBACK: begin
        rf_we_c = writes_rd(opcode) && (rd != 5'd0);
        if (opcode == OP_LOAD) rf_wdata_c = mdr_q;
        else if (is_jump)      rf_wdata_c = pc + 32'd4;
        else                   rf_wdata_c = alu_q;
        if (((opcode == OP_BRANCH) && taken_q) || is_jump) pc_d = alu_q;
        else                                               pc_d = pc + 32'd4;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Control and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      taken_q <= 1'b0;
      mdr_q   <= '0;
    end else begin
      state   <= state_d;
      pc      <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      alu_q   <= alu_d;
      taken_q <= taken_d;
      mdr_q   <= mdr_d;
    end
  end

  // Register file; x0 never written so it always reads zero
  always_ff @(posedge clk) begin
    if (rst)          regs <= '{default: '0};
    else if (rf_we_c) regs[rd] <= rf_wdata_c;
  end
endmodule

// File: tb/tb_five_cycle_cpu.sv
// Self-checking bench for five_cycle_cpu: directed programs plus random programs
// compared against an instruction-level reference model.
module tb_five_cycle_cpu;
  import five_cycle_cpu_pkg::*;

  localparam int unsigned MEM_WORDS = 1024;
  localparam logic [31:0] END_PC    = 32'd92;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  five_cycle_cpu #(.MEM_WORDS(MEM_WORDS), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_mem  [0:MEM_WORDS-1];
  logic [31:0] m_regs [0:31];
  logic [31:0] m_pc;
  logic [31:0] pc_hist [$];
  logic [31:0] prog [$];
  state_t      seq [5] = '{FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP_OP};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
  endfunction
  // h is the branch offset divided by two
  function automatic logic [31:0] enc_b(input logic [11:0] h, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {h[11], h[9:4], rs2, rs1, f3, h[3:0], h[10], OP_BRANCH};
  endfunction
  // h is the jump offset divided by two
  function automatic logic [31:0] enc_j(input logic [19:0] h, input logic [4:0] rd);
    return {h[19], h[9:0], h[10], h[18:11], rd, OP_JAL};
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic sub_sra,
      input logic [31:0] x, input logic [31:0] y);
    case (f3)
      3'd0:    return sub_sra ? x - y : x + y;
      3'd1:    return x << y[4:0];
      3'd2:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3:    return (x < y) ? 32'd1 : 32'd0;
      3'd4:    return x ^ y;
      3'd5:    return sub_sra ? 32'($signed(x) >>> y[4:0]) : x >> y[4:0];
      3'd6:    return x | y;
      default: return x & y;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] x,
      input logic [31:0] y);
    case (f3)
      3'd0:    return x == y;
      3'd1:    return x != y;
      3'd4:    return $signed(x) < $signed(y);
      3'd5:    return $signed(x) >= $signed(y);
      3'd6:    return x < y;
      3'd7:    return x >= y;
      default: return 1'b0;
    endcase
  endfunction

  // Execute one whole instruction on the model state
  task automatic ref_step();
    logic [31:0] ins, a, b, imm_i, imm_s, imm_b, imm_u, imm_j, res, nxt, ea;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        wr;
    ins   = m_mem[10'(m_pc >> 2)];
    op    = ins[6:0];
    rd    = ins[11:7];
    f3    = ins[14:12];
    a     = m_regs[ins[19:15]];
    b     = m_regs[ins[24:20]];
    imm_i = {{20{ins[31]}}, ins[31:20]};
    imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    imm_u = {ins[31:12], 12'h000};
    imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    nxt   = m_pc + 32'd4;
    res   = '0;
    wr    = 1'b0;
    case (op)
      7'h33: begin res = ref_alu(f3, ins[30], a, b); wr = 1'b1; end
      7'h13: begin res = ref_alu(f3, ins[30] && (f3 == 3'd5), a, imm_i); wr = 1'b1; end
      7'h03: begin ea = a + imm_i; res = m_mem[10'(ea >> 2)]; wr = 1'b1; end
      7'h23: begin ea = a + imm_s; m_mem[10'(ea >> 2)] = b; end
      7'h63: if (ref_taken(f3, a, b)) nxt = m_pc + imm_b;
      7'h37: begin res = imm_u; wr = 1'b1; end
      7'h17: begin res = m_pc + imm_u; wr = 1'b1; end
      7'h6F: begin res = m_pc + 32'd4; nxt = m_pc + imm_j; wr = 1'b1; end
      7'h67: begin res = m_pc + 32'd4; nxt = (a + imm_i) & ~32'h1; wr = 1'b1; end
      default: ;
    endcase
    if (wr && (rd != 5'd0)) m_regs[rd] = res;
    m_pc = nxt;
    pc_hist.push_back(m_pc);
  endtask

  // Hold reset two clocks while loading memory (random data region at words 128..255)
  task automatic load_program(input logic [31:0] p[$]);
    logic [31:0] w;
    rst = 1'b1;
    for (int i = 0; i < int'(MEM_WORDS); i++) begin
      w = (i >= 128 && i < 256) ? $urandom() : 32'h0;
      if (i < p.size()) w = p[i];
      dut.memory.data[10'(i)] = w;
      m_mem[10'(i)] = w;
    end
    for (int i = 0; i < 32; i++) m_regs[5'(i)] = '0;
    m_pc    = '0;
    pc_hist = {32'h0};
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Random forward-only program ending in a self-loop at END_PC
  task automatic gen_program();
    logic [31:0] w;
    logic [4:0]  rd, rs1, rs2, sh;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [19:0] hi20;
    logic [24:0] hi25;
    int          k, kmax;
    prog = {};
    for (int i = 0; i < 23; i++) begin
      rd   = 5'($urandom_range(0, 7));
      rs1  = 5'($urandom_range(0, 7));
      rs2  = 5'($urandom_range(0, 7));
      f3   = 3'($urandom_range(0, 7));
      sh   = 5'($urandom_range(0, 31));
      imm  = 12'($urandom_range(0, 4095));
      hi20 = 20'($urandom());
      hi25 = 25'($urandom());
      kmax = (23 - i) < 3 ? (23 - i) : 3;
      k    = int'($urandom_range(1, kmax));
      case ($urandom_range(0, 9))
        0: w = enc_r(((f3 == 3'd0 || f3 == 3'd5) && imm[0]) ? 7'h20 : 7'h00, rs2, rs1, f3, rd);
        1: begin
          if (f3 == 3'd1)      imm = {7'h00, sh};
          else if (f3 == 3'd5) imm = {imm[0] ? 7'h20 : 7'h00, sh};
          w = enc_i(imm, rs1, f3, rd, OP_IMM);
        end
        2: w = {hi20, rd, OP_LUI};
        3: w = {hi20, rd, OP_AUIPC};
        4: w = enc_i(12'(512 + 4 * int'(imm[6:0])), 5'd0, 3'b010, rd, OP_LOAD);
        5: w = enc_s(12'(512 + 4 * int'(imm[6:0])), rs2, 5'd0);
        6: begin
          if (f3 == 3'd2 || f3 == 3'd3) f3 = f3 + 3'd2;
          w = enc_b(12'(2 * k), rs2, rs1, f3);
        end
        7: w = enc_j(20'(2 * k), rd);
        8: w = enc_i(12'(4 * (i + k)), 5'd0, 3'b000, rd, OP_JALR);
        default: w = {hi25, 7'h0B};
      endcase
      prog.push_back(w);
    end
    prog.push_back(32'h0000006F);
  endtask

  // Model runs to the self-loop, then two more self-loop iterations
  task automatic run_model(output int n_instr);
    n_instr = 0;
    while (m_pc != END_PC && n_instr < 100) begin
      ref_step();
      n_instr++;
    end
    ref_step();
    ref_step();
    n_instr += 2;
  endtask

  task automatic test_arith();
    prog = {enc_i(12'd5, 5'd0, 3'd0, 5'd1, OP_IMM), enc_i(12'hFFD, 5'd0, 3'd0, 5'd2, OP_IMM),
            enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4)};
    load_program(prog);
    repeat (20) tick();
    n_checks++; if (dut.regs[1] !== 32'd5) $display("FAIL arith_x1: got %h expected %h", dut.regs[1], 32'd5); else n_pass++;
    n_checks++; if (dut.regs[2] !== 32'hFFFFFFFD) $display("FAIL arith_x2: got %h expected %h", dut.regs[2], 32'hFFFFFFFD); else n_pass++;
    n_checks++; if (dut.regs[3] !== 32'd2) $display("FAIL arith_x3: got %h expected %h", dut.regs[3], 32'd2); else n_pass++;
    n_checks++; if (dut.regs[4] !== 32'd8) $display("FAIL arith_x4: got %h expected %h", dut.regs[4], 32'd8); else n_pass++;
    n_checks++; if (dut.pc !== 32'd16) $display("FAIL arith_pc: got %h expected %h", dut.pc, 32'd16); else n_pass++;
  endtask

  task automatic test_reset();
    int n_bad, first_bad;
    prog = {32'h0000006F};
    for (int i = 1; i < 8; i++) prog.push_back($urandom());
    load_program(prog);
    n_checks++; if (dut.pc !== 32'h0) $display("FAIL reset_pc: got %h expected %h", dut.pc, 32'h0); else n_pass++;
    n_checks++; if (dut.state !== FETCH) $display("FAIL reset_state: got %0d expected %0d", dut.state, FETCH); else n_pass++;
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (dut.regs[5'(i)] !== 32'h0) $display("FAIL reset_x%0d: got %h expected %h", i, dut.regs[5'(i)], 32'h0);
      else n_pass++;
    end
    repeat (10) tick();
    n_bad = 0;
    first_bad = 0;
    for (int i = 0; i < int'(MEM_WORDS); i++) begin
      if (dut.memory.data[10'(i)] !== m_mem[10'(i)]) begin
        if (n_bad == 0) first_bad = i;
        n_bad++;
      end
    end
    n_checks++;
    if (n_bad != 0)
      $display("FAIL reset_mem_preserved: %0d words differ, word %0d got %h expected %h",
               n_bad, first_bad, dut.memory.data[10'(first_bad)], m_mem[10'(first_bad)]);
    else n_pass++;
    n_checks++; if (dut.pc !== 32'h0) $display("FAIL self_loop_pc: got %h expected %h", dut.pc, 32'h0); else n_pass++;
  endtask

  task automatic test_load_store();
    prog = {};
    for (int i = 0; i < 65; i++) prog.push_back(32'h0);
    prog[0]  = enc_i(12'd256, 5'd0, 3'b010, 5'd5, OP_LOAD);
    prog[1]  = enc_s(12'd260, 5'd5, 5'd0);
    prog[64] = 32'hDEADBEEF;
    load_program(prog);
    repeat (10) tick();
    n_checks++; if (dut.regs[5] !== 32'hDEADBEEF) $display("FAIL lw_x5: got %h expected %h", dut.regs[5], 32'hDEADBEEF); else n_pass++;
    n_checks++; if (dut.memory.data[65] !== 32'hDEADBEEF) $display("FAIL sw_data65: got %h expected %h", dut.memory.data[65], 32'hDEADBEEF); else n_pass++;
  endtask

  task automatic test_branch();
    prog = {enc_i(12'd7, 5'd0, 3'd0, 5'd1, OP_IMM), enc_i(12'd7, 5'd0, 3'd0, 5'd2, OP_IMM),
            enc_b(12'd4, 5'd2, 5'd1, 3'd0), 32'h0, enc_b(12'd4, 5'd2, 5'd1, 3'd1)};
    load_program(prog);
    repeat (14) tick();
    n_checks++; if (dut.pc !== 32'd8) $display("FAIL beq_pc_before_wb: got %h expected %h", dut.pc, 32'd8); else n_pass++;
    tick();
    n_checks++; if (dut.pc !== 32'd16) $display("FAIL beq_taken_pc: got %h expected %h", dut.pc, 32'd16); else n_pass++;
    repeat (5) tick();
    n_checks++; if (dut.pc !== 32'd20) $display("FAIL bne_not_taken_pc: got %h expected %h", dut.pc, 32'd20); else n_pass++;
  endtask

  task automatic test_x0();
    prog = {enc_i(12'd9, 5'd0, 3'd0, 5'd0, OP_IMM), enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd6)};
    load_program(prog);
    repeat (10) tick();
    n_checks++; if (dut.regs[0] !== 32'h0) $display("FAIL x0_write_discarded: got %h expected %h", dut.regs[0], 32'h0); else n_pass++;
    n_checks++; if (dut.regs[6] !== 32'h0) $display("FAIL x0_reads_zero: got %h expected %h", dut.regs[6], 32'h0); else n_pass++;
    n_checks++; if (dut.pc !== 32'd8) $display("FAIL x0_pc: got %h expected %h", dut.pc, 32'd8); else n_pass++;
  endtask

  // PC and phase checked after every clock of a random program
  task automatic test_timing();
    int n;
    gen_program();
    load_program(prog);
    run_model(n);
    for (int t = 1; t <= n * 5; t++) begin
      tick();
      n_checks++;
      if (dut.pc !== pc_hist[t / 5]) $display("FAIL timing_pc_t%0d: got %h expected %h", t, dut.pc, pc_hist[t / 5]);
      else n_pass++;
      n_checks++;
      if (dut.state !== seq[t % 5]) $display("FAIL timing_state_t%0d: got %0d expected %0d", t, dut.state, seq[t % 5]);
      else n_pass++;
    end
  endtask

  task automatic test_random_programs();
    int n, n_bad, first_bad;
    for (int r = 0; r < 4; r++) begin
      gen_program();
      load_program(prog);
      run_model(n);
      repeat (n * 5) tick();
      n_checks++;
      if (dut.pc !== m_pc) $display("FAIL rand%0d_pc: got %h expected %h", r, dut.pc, m_pc);
      else n_pass++;
      for (int i = 0; i < 32; i++) begin
        n_checks++;
        if (dut.regs[5'(i)] !== m_regs[5'(i)])
          $display("FAIL rand%0d_x%0d: got %h expected %h", r, i, dut.regs[5'(i)], m_regs[5'(i)]);
        else n_pass++;
      end
      n_bad = 0;
      first_bad = 0;
      for (int i = 0; i < int'(MEM_WORDS); i++) begin
        if (dut.memory.data[10'(i)] !== m_mem[10'(i)]) begin
          if (n_bad == 0) first_bad = i;
          n_bad++;
        end
      end
      n_checks++;
      if (n_bad != 0)
        $display("FAIL rand%0d_mem: %0d words differ, word %0d got %h expected %h", r, n_bad,
                 first_bad, dut.memory.data[10'(first_bad)], m_mem[10'(first_bad)]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_sw();
    prog = {enc_i(12'h055, 5'd0, 3'd0, 5'd1, OP_IMM), enc_s(12'd400, 5'd1, 5'd0), 32'h0000006F};
    load_program(prog);
    repeat (8) tick();
    n_checks++; if (dut.state !== MEMORY) $display("FAIL midsw_in_memory: got %0d expected %0d", dut.state, MEMORY); else n_pass++;
    n_checks++; if (dut.pc !== 32'd4) $display("FAIL midsw_pc_before: got %h expected %h", dut.pc, 32'd4); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (dut.memory.data[100] !== 32'h0) $display("FAIL midsw_no_write: got %h expected %h", dut.memory.data[100], 32'h0); else n_pass++;
    n_checks++; if (dut.pc !== 32'h0) $display("FAIL midsw_pc: got %h expected %h", dut.pc, 32'h0); else n_pass++;
    n_checks++; if (dut.state !== FETCH) $display("FAIL midsw_state: got %0d expected %0d", dut.state, FETCH); else n_pass++;
    n_checks++; if (dut.regs[1] !== 32'h0) $display("FAIL midsw_x1_cleared: got %h expected %h", dut.regs[1], 32'h0); else n_pass++;
  endtask

  initial begin
    test_arith();
    test_reset();
    test_load_store();
    test_branch();
    test_x0();
    test_timing();
    test_random_programs();
    test_reset_mid_sw();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
